mem_access_ctrl: RTL and testbench

Sequencing controller that owns every access to `MainMemory`. It multiplexes the front-panel program loader (program mode) and the CPU bus (run mode) onto the memory's address, enable and manual-data pins. It generates setup and strobe phases, holding each strobe for a fixed settle time, captures read data from the W-bus, and returns a one-cycle acknowledge to the requester. It sits between the loader/CPU control unit and `MainMemory`.

---
 rtl/sap_mem_pkg.sv | 20 ++
 rtl/mem_access_ctrl.sv | 150 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sap_mem_pkg.sv
// Shared definitions for the SAP main-memory access path.
package sap_mem_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        W_SETUP,
        W_STROBE,
        R_WAIT,
        ACK
    } mem_state_t;

    typedef enum logic {
        OWN_PROG,
        OWN_CPU
    } mem_owner_t;

endpackage

// File: rtl/mem_access_ctrl.sv
// Arbitrates loader/CPU access to MainMemory and sequences setup, strobe and ack phases.
//
// state    | meaning
// IDLE     | no transaction; requester selected by run
// W_SETUP  | address/data/manual driven, write enable low
// W_STROBE | write enable held for SETTLE cycles
// R_WAIT   | read enable held for SETTLE cycles, data captured on exit
// ACK      | one-cycle ack to the latched owner, all strobes low
module mem_access_ctrl
    import sap_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              prog_req,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic              prog_ack,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic              mem_manual,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_bus,
    output logic              busy
);

    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

    mem_state_t        state_q, state_d;
    mem_owner_t        owner_q, owner_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic              manual_q, manual_d;
    logic              busy_q, busy_d;
    logic              prog_ack_q, prog_ack_d;
    logic              cpu_ack_q, cpu_ack_d;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (!run && prog_req) begin
                    state_d = W_SETUP;
                    owner_d = OWN_PROG;
                    addr_d  = prog_addr;
                    wdata_d = prog_data;
                end else if (run && cpu_req) begin
                    owner_d = OWN_CPU;
                    addr_d  = cpu_addr;
                    if (cpu_we) begin
                        state_d = W_SETUP;
                        wdata_d = cpu_wdata;
                    end else begin
                        state_d = R_WAIT;
                        cnt_d   = SETTLE_M1;
                    end
                end
            end
            W_SETUP: begin
                state_d = W_STROBE;
                cnt_d   = SETTLE_M1;
            end
            W_STROBE: begin
                if (cnt_q == 4'd0) state_d = ACK;
                else               cnt_d   = cnt_q - 4'd1;
            end
            R_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ACK;
                    rdata_d = mem_bus;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered pins line up with the state.
    always_comb begin
        we_d       = (state_d == W_STROBE);
        re_d       = (state_d == R_WAIT);
        manual_d   = (state_d == W_SETUP) || (state_d == W_STROBE);
        busy_d     = (state_d != IDLE);
        prog_ack_d = (state_d == ACK) && (owner_q == OWN_PROG);
        cpu_ack_d  = (state_d == ACK) && (owner_q == OWN_CPU);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= OWN_PROG;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            manual_q   <= 1'b0;
            busy_q     <= 1'b0;
            prog_ack_q <= 1'b0;
            cpu_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            we_q       <= we_d;
            re_q       <= re_d;
            manual_q   <= manual_d;
            busy_q     <= busy_d;
            prog_ack_q <= prog_ack_d;
            cpu_ack_q  <= cpu_ack_d;
        end
    end

    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_we     = we_q;
    assign mem_re     = re_q;
    assign mem_manual = manual_q;
    assign cpu_rdata  = rdata_q;
    assign busy       = busy_q;
    assign prog_ack   = prog_ack_q;
    assign cpu_ack    = cpu_ack_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboarded bench for mem_access_ctrl with a behavioural MainMemory on the mem_* pins.
module tb_mem_access_ctrl;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 4;
    localparam int SETTLE = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              run;
    logic              prog_req;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic              prog_ack;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic              mem_re;
    logic              mem_manual;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_bus;
    logic              busy;

    mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst), .run(run),
        .prog_req(prog_req), .prog_addr(prog_addr), .prog_data(prog_data), .prog_ack(prog_ack),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re), .mem_manual(mem_manual),
        .mem_wdata(mem_wdata), .mem_bus(mem_bus), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural memory: manual write on the clock, combinational W-bus while reading.
    logic [DATA_W-1:0] mem_arr [256];
    logic [DATA_W-1:0] ref_mem [256];
    always @(posedge clk) if (mem_we && mem_manual) mem_arr[mem_addr] <= mem_wdata;
    assign mem_bus = mem_re ? mem_arr[mem_addr] : '0;

    // cyc counts rising edges; a request sampled at edge n acks after edge n+SETTLE+1 (write) or n+SETTLE (read).
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit                is_cpu;
        bit                is_read;
        logic [DATA_W-1:0] rdata;
        int                ack_cyc;
    } sb_t;
    sb_t sb[$];

    int errors = 0;
    int checks = 0;
    int overlap = 0;

    always @(negedge clk) begin
        sb_t e;
        if (mem_we && mem_re) overlap++;
        if (prog_ack || cpu_ack) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack prog_ack=%0b cpu_ack=%0b at cyc=%0d", prog_ack, cpu_ack, cyc);
            end else begin
                e = sb.pop_front();
                if ({prog_ack, cpu_ack} !== (e.is_cpu ? 2'b01 : 2'b10) || cyc !== e.ack_cyc) begin
                    errors++;
                    $display("FAIL ack_owner_time got prog/cpu=%b%b cyc=%0d expected cpu=%0b cyc=%0d",
                             prog_ack, cpu_ack, cyc, e.is_cpu, e.ack_cyc);
                end
                if (e.is_read) begin
                    checks++;
                    if (cpu_rdata !== e.rdata) begin
                        errors++;
                        $display("FAIL read_data got %h expected %h", cpu_rdata, e.rdata);
                    end
                end
            end
        end
    end

    task automatic do_txn(input bit is_cpu, input bit wr, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, output int n);
        sb_t        e;
        int         last;
        logic [2:0] exp_s;
        @(negedge clk);
        if (is_cpu) begin
            cpu_req = 1'b1; cpu_we = wr; cpu_addr = a; cpu_wdata = d;
        end else begin
            prog_req = 1'b1; prog_addr = a; prog_data = d;
        end
        n    = cyc + 1;
        last = wr ? SETTLE + 1 : SETTLE;
        e.is_cpu  = is_cpu;
        e.is_read = !wr;
        e.rdata   = ref_mem[a];
        e.ack_cyc = n + last;
        if (wr) ref_mem[a] = d;
        sb.push_back(e);
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            if (k == last)   exp_s = 3'b000;
            else if (!wr)    exp_s = 3'b010;
            else if (k == 0) exp_s = 3'b001;
            else             exp_s = 3'b101;
            checks++;
            if ({mem_we, mem_re, mem_manual} !== exp_s || (k < last && mem_addr !== a)
                || (wr && k < last && mem_wdata !== d)) begin
                errors++;
                $display("FAIL strobe k=%0d we/re/man=%b addr=%h wdata=%h expected %b addr=%h wdata=%h",
                         k, {mem_we, mem_re, mem_manual}, mem_addr, mem_wdata, exp_s, a, d);
            end
            if (k == 0) begin
                prog_addr = ~a; prog_data = ~d; cpu_addr = ~a; cpu_wdata = ~d;
            end
        end
        checks++;
        if ((is_cpu ? cpu_ack : prog_ack) !== 1'b1) begin
            errors++;
            $display("FAIL ack_pulse got prog=%0b cpu=%0b expected owner cpu=%0b", prog_ack, cpu_ack, is_cpu);
        end
        prog_req = 1'b0;
        cpu_req  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0;
        prog_req = 1'b0; prog_addr = '0; prog_data = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_we, mem_re, mem_manual, prog_ack, cpu_ack, busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b expected 000000", {mem_we, mem_re, mem_manual, prog_ack, cpu_ack, busy});
        end
        checks++;
        if ({mem_addr, mem_wdata, cpu_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_data addr=%h wdata=%h rdata=%h expected all 0", mem_addr, mem_wdata, cpu_rdata);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_prog_write();
        int n;
        run = 1'b0;
        do_txn(1'b0, 1'b1, 8'h0C, 4'hA, n);
        @(negedge clk);
        checks++;
        if (mem_arr[8'h0C] !== 4'hA) begin
            errors++;
            $display("FAIL prog_write_mem got %h expected a", mem_arr[8'h0C]);
        end
    endtask

    task automatic test_cpu_read();
        int n;
        run = 1'b1;
        do_txn(1'b1, 1'b0, 8'h0C, 4'h0, n);
        repeat (3) @(negedge clk);
        checks++;
        if (cpu_rdata !== 4'hA) begin
            errors++;
            $display("FAIL rdata_hold got %h expected a", cpu_rdata);
        end
    endtask

    task automatic test_cpu_write_read();
        int n;
        run = 1'b1;
        do_txn(1'b1, 1'b1, 8'h0A, 4'hE, n);
        checks++;
        if (cpu_rdata !== 4'hA) begin
            errors++;
            $display("FAIL rdata_after_write got %h expected a", cpu_rdata);
        end
        do_txn(1'b1, 1'b0, 8'h0A, 4'h0, n);
    endtask

    task automatic test_back_to_back();
        int n0, n1;
        run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_txn(1'b1, 1'b1, 8'(8'h20 + i), 4'($urandom_range(0, 15)), n1);
            if (i > 0) begin
                checks++;
                if (n1 - n0 !== SETTLE + 3) begin
                    errors++;
                    $display("FAIL write_throughput got %0d expected %0d", n1 - n0, SETTLE + 3);
                end
            end
            n0 = n1;
        end
        for (int i = 0; i < 3; i++) begin
            do_txn(1'b1, 1'b0, 8'(8'h20 + i), 4'h0, n1);
            if (i > 0) begin
                checks++;
                if (n1 - n0 !== SETTLE + 2) begin
                    errors++;
                    $display("FAIL read_throughput got %0d expected %0d", n1 - n0, SETTLE + 2);
                end
            end
            n0 = n1;
        end
    endtask

    task automatic test_ignore();
        @(negedge clk);
        run = 1'b1; prog_req = 1'b1; prog_addr = 8'h55; prog_data = 4'h5;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({mem_we, mem_re, mem_manual, busy} !== 4'b0) begin
                errors++;
                $display("FAIL ignore_prog got we/re/man/busy=%b expected 0000", {mem_we, mem_re, mem_manual, busy});
            end
        end
        prog_req = 1'b0; run = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h66;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({mem_we, mem_re, mem_manual, busy} !== 4'b0) begin
                errors++;
                $display("FAIL ignore_cpu got we/re/man/busy=%b expected 0000", {mem_we, mem_re, mem_manual, busy});
            end
        end
        cpu_req = 1'b0;
    endtask

    task automatic test_run_switch();
        sb_t e;
        int  n;
        bit  seen;
        run = 1'b0;
        @(negedge clk);
        prog_req = 1'b1; prog_addr = 8'h30; prog_data = 4'h5;
        n = cyc + 1;
        e.is_cpu = 1'b0; e.is_read = 1'b0; e.rdata = '0; e.ack_cyc = n + SETTLE + 1;
        ref_mem[8'h30] = 4'h5;
        sb.push_back(e);
        repeat (2) @(negedge clk);
        checks++;
        if (mem_we !== 1'b1) begin
            errors++;
            $display("FAIL switch_strobe got mem_we=%0b expected 1", mem_we);
        end
        run = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h0A;
        e.is_cpu = 1'b1; e.is_read = 1'b1; e.rdata = ref_mem[8'h0A]; e.ack_cyc = n + 2 * SETTLE + 3;
        sb.push_back(e);
        while (cyc < n + SETTLE + 1) @(negedge clk);
        checks++;
        if ({prog_ack, cpu_ack} !== 2'b10) begin
            errors++;
            $display("FAIL switch_owner got prog/cpu=%b expected 10", {prog_ack, cpu_ack});
        end
        prog_req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (cpu_ack) seen = 1'b1;
        end
        cpu_req = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL switch_cpu_timeout got no cpu_ack expected one within 30 cycles");
        end
        @(negedge clk);
        checks++;
        if (mem_arr[8'h30] !== 4'h5) begin
            errors++;
            $display("FAIL switch_mem got %h expected 5", mem_arr[8'h30]);
        end
    endtask

    task automatic test_reset_mid_strobe();
        run = 1'b0;
        @(negedge clk);
        prog_req = 1'b1; prog_addr = 8'h40; prog_data = 4'h3;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({mem_we, mem_manual, busy, mem_addr} !== '0) begin
            errors++;
            $display("FAIL async_reset got we=%0b man=%0b busy=%0b addr=%h expected all 0",
                     mem_we, mem_manual, busy, mem_addr);
        end
        prog_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mem_arr[8'h40] !== 4'h0) begin
            errors++;
            $display("FAIL reset_abort got busy=%0b mem=%h expected busy=0 mem=0", busy, mem_arr[8'h40]);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = '0;
            ref_mem[i] = '0;
        end
        test_reset();
        test_prog_write();
        test_cpu_read();
        test_cpu_write_read();
        test_back_to_back();
        test_ignore();
        test_run_switch();
        test_reset_mid_strobe();
        checks++;
        if (overlap !== 0) begin
            errors++;
            $display("FAIL we_re_overlap got %0d cycles expected 0", overlap);
        end
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL missing_acks got %0d outstanding expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
